vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 123 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns: solid, colour bars, checkerboard, scrolling bars.
// Pattern inputs are shadowed at the frame origin, so a frame never shows a mix of settings.
module vga_pattern_gen #(
  parameter int CW       = 1,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int BAR_W    = 80,
  parameter int CHK_LOG2 = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] fg_color,
  input  logic [3*CW-1:0] bg_color,
  output logic [3*CW-1:0] RGB,
  output logic            h_sync,
  output logic            v_sync,
  output logic            video_on,
  output logic [9:0]      pixel_x,
  output logic [9:0]      pixel_y,
  output logic            frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [DW-1:0]   div_cnt;
  logic [9:0]      h_cnt, v_cnt;
  logic [1:0]      sh_mode;
  logic [3*CW-1:0] sh_fg, sh_bg;
  logic [2:0]      scroll;
  logic [BW-1:0]   bar_px;
  logic [2:0]      bar_idx;

  logic            p_tick, h_end, v_end;
  logic            visible, hs_act, vs_act;
  logic [2:0]      bar_sel;
  logic [3*CW-1:0] pix_color;

  always_comb begin
    p_tick  = (div_cnt == DW'(CLK_DIV - 1));
    h_end   = (h_cnt == 10'(H_TOTAL - 1));
    v_end   = (v_cnt == 10'(V_TOTAL - 1));
    visible = (h_cnt < 10'(H_DISP)) && (v_cnt < 10'(V_DISP));
    hs_act  = (h_cnt >= 10'(H_DISP + H_FP)) && (h_cnt < 10'(H_DISP + H_FP + H_SYNC));
    vs_act  = (v_cnt >= 10'(V_DISP + V_FP)) && (v_cnt < 10'(V_DISP + V_FP + V_SYNC));
    bar_sel = (sh_mode == 2'd3) ? bar_idx + scroll : bar_idx;
    pix_color = '0;
    case (sh_mode)
      2'd0: pix_color = sh_fg;
      2'd2: pix_color = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? sh_fg : sh_bg;
      default: pix_color = {{CW{bar_sel[2]}}, {CW{bar_sel[1]}}, {CW{bar_sel[0]}}};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      sh_mode     <= '0;
      sh_fg       <= '0;
      sh_bg       <= '0;
      scroll      <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      RGB         <= '0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div_cnt     <= p_tick ? '0 : div_cnt + 1'b1;
      if (p_tick) begin
        RGB      <= visible ? pix_color : '0;
        h_sync   <= ~hs_act;
        v_sync   <= ~vs_act;
        video_on <= visible;
        pixel_x  <= h_cnt;
        pixel_y  <= v_cnt;
        if (h_end) begin
          // Bar state is cleared here so it already describes h_cnt=0 on the next tick.
          h_cnt   <= '0;
          bar_px  <= '0;
          bar_idx <= '0;
          if (v_end) begin
            v_cnt       <= '0;
            sh_mode     <= mode;
            sh_fg       <= fg_color;
            sh_bg       <= bg_color;
            scroll      <= scroll + 1'b1;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
          if (h_cnt < 10'(H_DISP)) begin
            if (bar_px == BW'(BAR_W - 1)) begin
              bar_px  <= '0;
              bar_idx <= bar_idx + 1'b1;
            end else begin
              bar_px <= bar_px + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a reduced timing grid; the model derives each
// expected pixel from the tick count since reset rather than from running counters.
module tb_vga_pattern_gen;

  localparam int HD = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VD = 16, VFP = 2, VS = 2, VBP = 2;
  localparam int D = 2, BARW = 4, CHK = 2;
  localparam int HT = HD + HFP + HS + HBP;
  localparam int VT = VD + VFP + VS + VBP;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [2:0] fg_color, bg_color;
  logic [2:0] RGB, rgb1;
  logic       h_sync, v_sync, video_on, frame_start;
  logic       hs1, vs1, von1, fs1;
  logic [9:0] pixel_x, pixel_y, x1, y1;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  vga_pattern_gen #(
    .CW(1), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(D), .BAR_W(BARW), .CHK_LOG2(CHK)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
    .RGB(RGB), .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  vga_pattern_gen #(
    .CW(1), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(1), .BAR_W(BARW), .CHK_LOG2(CHK)
  ) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
    .RGB(rgb1), .h_sync(hs1), .v_sync(vs1), .video_on(von1),
    .pixel_x(x1), .pixel_y(y1), .frame_start(fs1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic rec_t rst_rec();
    rec_t r;
    r.rgb = 3'b000; r.hs = 1'b1; r.vs = 1'b1; r.von = 1'b0; r.x = '0; r.y = '0;
    return r;
  endfunction

  function automatic logic [2:0] exp_color(input logic [1:0] md, input logic [2:0] fg,
                                           input logic [2:0] bg, input int scr,
                                           input int h, input int v);
    if (md == 2'd0) return fg;
    if (md == 2'd1) return 3'((h / BARW) % 8);
    if (md == 2'd2) return (((h >> CHK) ^ (v >> CHK)) & 1) != 0 ? fg : bg;
    return 3'((h / BARW + scr) % 8);
  endfunction

  // Reference model: tick k after release registers position k-1 of the raster.
  rec_t       q[$];
  int         m_clk, m_frame, m_h, m_v;
  logic [1:0] sh_mode;
  logic [2:0] sh_fg, sh_bg, m_scroll;
  logic       exp_fs;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_clk <= 0; m_frame <= 0; m_h <= 0; m_v <= 0;
      sh_mode <= '0; sh_fg <= '0; sh_bg <= '0; m_scroll <= '0;
      exp_fs <= 1'b0;
      q.delete();
    end else begin : mdl
      int n, t, p, h, v;
      rec_t r;
      n = m_clk + 1;
      m_clk <= n;
      exp_fs <= 1'b0;
      if (n % D == 0) begin
        t = n / D - 1;
        p = t % FR;
        h = p % HT;
        v = p / HT;
        r.von = (h < HD) && (v < VD);
        r.hs  = !((h >= HD + HFP) && (h < HD + HFP + HS));
        r.vs  = !((v >= VD + VFP) && (v < VD + VFP + VS));
        r.x   = 10'(h);
        r.y   = 10'(v);
        r.rgb = r.von ? exp_color(sh_mode, sh_fg, sh_bg, int'(m_scroll), h, v) : 3'b000;
        q.push_back(r);
        m_frame <= t / FR;
        m_h <= h;
        m_v <= v;
        if (p == FR - 1) begin
          sh_mode <= mode; sh_fg <= fg_color; sh_bg <= bg_color;
          m_scroll <= m_scroll + 3'd1;
          exp_fs <= 1'b1;
        end
      end
    end
  end

  rec_t cur = rst_rec();
  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset) cur = rst_rec();
      else if (q.size() > 0) cur = q.pop_front();
      check("rgb", 32'(RGB), 32'(cur.rgb));
      check("h_sync", 32'(h_sync), 32'(cur.hs));
      check("v_sync", 32'(v_sync), 32'(cur.vs));
      check("video_on", 32'(video_on), 32'(cur.von));
      check("pixel_x", 32'(pixel_x), 32'(cur.x));
      check("pixel_y", 32'(pixel_y), 32'(cur.y));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  // Sync pulse measurement in clocks, for both divider builds.
  int cyc = 0;
  int hs_fall = 0, hs_per = 0, hs_low = 0, vs_fall = 0, vs_per = 0, vs_low = 0;
  int hs1_fall = 0, hs1_per = 0, hs1_low = 0, vs1_fall = 0, vs1_per = 0, vs1_low = 0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_hs1 = 1'b1, p_vs1 = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (p_hs && !h_sync) begin if (hs_fall != 0) hs_per = cyc - hs_fall; hs_fall = cyc; end
    if (!p_hs && h_sync) hs_low = cyc - hs_fall;
    if (p_vs && !v_sync) begin if (vs_fall != 0) vs_per = cyc - vs_fall; vs_fall = cyc; end
    if (!p_vs && v_sync) vs_low = cyc - vs_fall;
    if (p_hs1 && !hs1) begin if (hs1_fall != 0) hs1_per = cyc - hs1_fall; hs1_fall = cyc; end
    if (!p_hs1 && hs1) hs1_low = cyc - hs1_fall;
    if (p_vs1 && !vs1) begin if (vs1_fall != 0) vs1_per = cyc - vs1_fall; vs1_fall = cyc; end
    if (!p_vs1 && vs1) vs1_low = cyc - vs1_fall;
    p_hs = h_sync; p_vs = v_sync; p_hs1 = hs1; p_vs1 = vs1;
  end

  task automatic wait_frame(input int f);
    for (int i = 0; i < 20000 && m_frame < f; i++) @(negedge clk);
    check("wait_frame", 32'(m_frame >= f), 32'd1);
  endtask

  task automatic wait_pos(input int f, input int v, input int h);
    bit hit = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (m_frame == f && m_v == v && m_h == h) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("wait_pos", 32'(hit), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, 32'(RGB), 32'd0);
    check({tag, "_hs"}, 32'(h_sync), 32'd1);
    check({tag, "_vs"}, 32'(v_sync), 32'd1);
    check({tag, "_von"}, 32'(video_on), 32'd0);
    check({tag, "_x"}, 32'(pixel_x), 32'd0);
    check({tag, "_y"}, 32'(pixel_y), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; fg_color = 3'b101; bg_color = 3'b010;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Frame 0 runs on cleared shadows; frame 1 shows solid 101.
    wait_frame(2);
    check("hs_period", 32'(hs_per), 32'(HT * D));
    check("hs_low", 32'(hs_low), 32'(HS * D));
    check("vs_period", 32'(vs_per), 32'(FR * D));
    check("vs_low", 32'(vs_low), 32'(VS * HT * D));
    check("hs_period_div1", 32'(hs1_per), 32'(HT));
    check("hs_low_div1", 32'(hs1_low), 32'(HS));
    check("vs_period_div1", 32'(vs1_per), 32'(FR));
    check("vs_low_div1", 32'(vs1_low), 32'(VS * HT));

    wait_pos(2, VD / 2, 5);
    mode = 2'd1;
    wait_pos(3, VD / 2, 20);
    mode = 2'd2; fg_color = 3'b111; bg_color = 3'b000;
    wait_pos(4, 3, 10);
    mode = 2'd3;
    // Frames 5..9 scroll through 5,6,7,0,1.
    wait_frame(10);

    wait_pos(10, 3, 15);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    check("rel_tick0_von", 32'(video_on), 32'd0);
    check("rel_tick0_x", 32'(pixel_x), 32'd0);
    @(posedge clk) #1;
    check("rel_tick1_von", 32'(video_on), 32'd1);
    check("rel_tick1_x", 32'(pixel_x), 32'd0);
    check("rel_tick1_y", 32'(pixel_y), 32'd0);
    check("rel_tick1_rgb", 32'(RGB), 32'd0);

    wait_frame(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
